data_memory_banked: RTL and testbench
=====================================

# data_memory_banked

Parametrised, handshaked successor to the fixed 64-byte data memory. Storage is row-organised, WORD_BYTES bytes per row, with big-endian byte addressing: the byte at the lowest address is the word MSB. It supports byte and word accesses at any byte address. A word access that crosses a row boundary is split into two row cycles by a small FSM. Out-of-range requests are flagged, and the memory self-clears after reset. It sits between the CPU load/store stage and data storage.

## Interface
- DEPTH_BYTES, 64, total bytes; multiple of WORD_BYTES
- WORD_BYTES, 2, bytes per word and per row; power of two, ≥2
- ROWS, DEPTH_BYTES/WORD_BYTES, derived; not overridable
- clock  in  1  single clock; all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted this cycle
- req_write  in  1  1 = write, 0 = read
- req_size  in  1  0 = byte, 1 = word
- req_addr  in  16  byte address
- req_wdata  in  8*WORD_BYTES  write data; byte writes use [7:0]
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  8*WORD_BYTES  read data; 0 for writes and errors
- rsp_error  out  1  request was out of range; valid with rsp_valid

## Operation
- FSM states: INIT, IDLE, SPLIT.
- INIT: a row counter writes zero to row 0..ROWS-1, one row per cycle. After the last row the FSM goes to IDLE. req_ready=0.
- IDLE: req_ready=1. A request is accepted on the cycle where req_valid and req_ready are both 1.
- Range check: the request is in range iff req_addr + size_bytes - 1 < DEPTH_BYTES, where size_bytes is 1 or WORD_BYTES.
- Out of range: no memory change. rsp_error=1, rsp_rdata=0, and the FSM stays in IDLE.
- Byte access: row = addr/WORD_BYTES, lane = addr%WORD_BYTES. A read returns the byte zero-extended in rsp_rdata.
- Word access, aligned (lane 0): the whole row is read or written in the accept cycle.
- Word access, misaligned: in the accept cycle, lanes lane..WORD_BYTES-1 of the row are accessed. The FSM goes to SPLIT. In SPLIT, lanes 0..lane-1 of row+1 are accessed, then the FSM returns to IDLE.
- In SPLIT, req_ready=0. The request fields are captured at accept, so the requester may change its inputs afterwards.
- Big-endian throughout: address addr maps to bits [8*WORD_BYTES-1 -: 8] of a word.
- Reset asserted in any state:
  - next state INIT, row counter 0, outputs cleared;
  - a pending SPLIT half is discarded and no response is produced;
  - INIT then clears all contents.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, state=INIT.
- INIT lasts exactly ROWS cycles after reset_n rises. req_ready goes to 1 on the cycle after the last clear.
- Writes commit on the accept edge. For misaligned word writes, the second half commits on the SPLIT edge.
- Latency from accept to rsp_valid:
  - 1 cycle for a byte access, an aligned word access, or an error;
  - 2 cycles for a misaligned word access.
- rsp_valid is a single-cycle pulse; there is no backpressure.
- Throughput: one accept per cycle for non-split accesses; a split access blocks the next request for one cycle.
- Read-after-write: a read accepted on the cycle after a write completes returns the new data. There is no bypass path, because the write has already committed.
- rsp_rdata and rsp_error are valid only while rsp_valid=1. They hold 0 otherwise.

## Structure
- Package data_mem_pkg contains:
  - mem_state_e {INIT, IDLE, SPLIT};
  - mem_size_e {SIZE_BYTE, SIZE_WORD};
  - the byte-lane/endianness helper functions.
- Sub-module mem_row_bank: ROWS × (8*WORD_BYTES) array with per-lane byte enables, a synchronous write port and a combinational read port. The top level holds the FSM, the range check, lane steering and the response registers.

## Test plan
All scenarios use the defaults DEPTH_BYTES=64, WORD_BYTES=2.
- Reset low for 1 cycle, then high -> req_ready=0 for 32 cycles, then 1. A word read at addr 0 -> rsp_rdata=0x0000, rsp_error=0, one cycle after accept.
- Word write 0x1234 at addr 4, then word read at addr 4 -> 0x1234. Byte read at addr 5 -> 0x0034. Each response arrives 1 cycle after accept.
- Misaligned word write 0xABCD at addr 7 -> req_ready=0 for one cycle, rsp_valid 2 cycles after accept. Then:
  - byte read at addr 7 -> 0x00AB;
  - byte read at addr 8 -> 0x00CD;
  - word read at addr 6 -> 0x00AB.
- Out-of-range requests, with byte 63 preset to 0x5A:
  - word write at addr 63 -> rsp_error=1, rsp_rdata=0, byte 63 still 0x5A;
  - byte read at addr 64 -> rsp_error=1.
- Reset during SPLIT of a misaligned write at addr 9 -> no rsp_valid, INIT re-runs for 32 cycles, and a later word read at addr 9 -> 0x0000.
- Back-to-back aligned writes at addrs 0, 2, 4 on consecutive cycles -> three accepts and three rsp_valid pulses on consecutive cycles. Read-back returns the written values.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and byte-lane helpers for the banked data memory.
// Lane 0 of a row holds the lowest byte address and sits in the word MSB (big-endian).
package data_mem_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    SPLIT
  } mem_state_e;

  typedef enum logic {
    SIZE_BYTE,
    SIZE_WORD
  } mem_size_e;

  // Bit position of the LSB of a byte lane inside a word.
  function automatic int unsigned lane_lsb(int unsigned lane, int unsigned word_bytes);
    return 8 * (word_bytes - 1 - lane);
  endfunction

  // Number of bytes touched by an access of the given size.
  function automatic int unsigned size_bytes(mem_size_e size, int unsigned word_bytes);
    return (size == SIZE_WORD) ? word_bytes : 1;
  endfunction

endpackage

// File: rtl/mem_row_bank.sv
// Row storage: ROWS x (8*WORD_BYTES) array.
// Ports: clock; write port (wr_en, wr_row, wr_be per lane, wr_data) committed on posedge;
// combinational read port (rd_row -> rd_data).
import data_mem_pkg::*;

module mem_row_bank #(
  parameter int unsigned ROWS       = 32,
  parameter int unsigned WORD_BYTES = 2
) (
  input  logic                          clock,
  input  logic                          wr_en,
  input  logic [$clog2(ROWS)-1:0]       wr_row,
  input  logic [WORD_BYTES-1:0]         wr_be,
  input  logic [8*WORD_BYTES-1:0]       wr_data,
  input  logic [$clog2(ROWS)-1:0]       rd_row,
  output logic [8*WORD_BYTES-1:0]       rd_data
);

  localparam int unsigned WORD_W = 8 * WORD_BYTES;

  logic [WORD_W-1:0] mem [ROWS];

  // Byte-enabled write; be bit j selects lane j (big-endian position).
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int unsigned j = 0; j < WORD_BYTES; j++) begin
        if (wr_be[j]) begin
          mem[wr_row][lane_lsb(j, WORD_BYTES) +: 8] <= wr_data[lane_lsb(j, WORD_BYTES) +: 8];
        end
      end
    end
  end

  assign rd_data = mem[rd_row];

endmodule

// File: rtl/data_memory_banked.sv
// Handshaked, row-organised big-endian data memory with split misaligned word accesses.
// Ports: clock, reset_n (sync, active-low); request req_valid/req_ready/req_write/req_size/
// req_addr/req_wdata; response rsp_valid (1-cycle pulse), rsp_rdata, rsp_error.
import data_mem_pkg::*;

module data_memory_banked #(
  parameter int unsigned DEPTH_BYTES = 64,
  parameter int unsigned WORD_BYTES  = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_size,
  input  logic [15:0]             req_addr,
  input  logic [8*WORD_BYTES-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [8*WORD_BYTES-1:0] rsp_rdata,
  output logic                    rsp_error
);

  localparam int unsigned ROWS   = DEPTH_BYTES / WORD_BYTES;
  localparam int unsigned WORD_W = 8 * WORD_BYTES;
  localparam int unsigned LANE_W = $clog2(WORD_BYTES);
  localparam int unsigned ROW_W  = $clog2(ROWS);

  mem_state_e         state, state_n;
  logic [ROW_W-1:0]   row_cnt, row_cnt_n;

  logic [ROW_W-1:0]   req_row;
  logic [LANE_W-1:0]  req_lane;
  int unsigned        req_lsb;
  mem_size_e          size;
  logic [16:0]        last_addr;
  logic               in_range;
  logic               accept;

  logic               wr_en;
  logic [ROW_W-1:0]   wr_row, rd_row;
  logic [WORD_BYTES-1:0] wr_be;
  logic [WORD_W-1:0]  wr_data, rd_data;

  // Second-half context captured at accept of a misaligned word access.
  logic               capture;
  logic [ROW_W-1:0]   sp_row;
  logic [LANE_W-1:0]  sp_lane;
  logic               sp_write;
  logic [WORD_W-1:0]  sp_wdata, sp_part;

  logic               ready_n, valid_n, error_n;
  logic [WORD_W-1:0]  rdata_n;

  assign req_row   = req_addr[LANE_W +: ROW_W];
  assign req_lane  = req_addr[LANE_W-1:0];
  assign req_lsb   = lane_lsb(32'(req_lane), WORD_BYTES);
  assign size      = mem_size_e'(req_size);
  assign last_addr = 17'(req_addr) + 17'(size_bytes(size, WORD_BYTES) - 1);
  assign in_range  = last_addr < 17'(DEPTH_BYTES);
  assign accept    = req_valid & req_ready;

  mem_row_bank #(
    .ROWS       (ROWS),
    .WORD_BYTES (WORD_BYTES)
  ) u_bank (
    .clock   (clock),
    .wr_en   (wr_en & reset_n),
    .wr_row  (wr_row),
    .wr_be   (wr_be),
    .wr_data (wr_data),
    .rd_row  (rd_row),
    .rd_data (rd_data)
  );

  // State, counter, split context and response registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= INIT;
      row_cnt   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      sp_row    <= '0;
      sp_lane   <= '0;
      sp_write  <= 1'b0;
      sp_wdata  <= '0;
      sp_part   <= '0;
    end else begin
      state     <= state_n;
      row_cnt   <= row_cnt_n;
      req_ready <= ready_n;
      rsp_valid <= valid_n;
      rsp_rdata <= rdata_n;
      rsp_error <= error_n;
      if (capture) begin
        sp_row   <= req_row + ROW_W'(1);
        sp_lane  <= req_lane;
        sp_write <= req_write;
        sp_wdata <= req_wdata;
        sp_part  <= rd_data << (8 * 32'(req_lane));
      end
    end
  end

  // Next-state, memory port steering and next response values.
  always_comb begin
    state_n   = state;
    row_cnt_n = row_cnt;
    wr_en     = 1'b0;
    wr_row    = '0;
    wr_be     = '0;
    wr_data   = '0;
    rd_row    = req_row;
    capture   = 1'b0;
    valid_n   = 1'b0;
    rdata_n   = '0;
    error_n   = 1'b0;

    case (state)
      INIT: begin
        wr_en  = 1'b1;
        wr_row = row_cnt;
        wr_be  = '1;
        if (32'(row_cnt) == ROWS - 1) begin
          state_n = IDLE;
        end else begin
          row_cnt_n = row_cnt + ROW_W'(1);
        end
      end

      IDLE: begin
        if (accept) begin
          if (!in_range) begin
            valid_n = 1'b1;
            error_n = 1'b1;
          end else if (size == SIZE_BYTE) begin
            wr_en          = req_write;
            wr_row         = req_row;
            wr_be[req_lane] = 1'b1;
            wr_data        = WORD_W'(req_wdata[7:0]) << req_lsb;
            valid_n        = 1'b1;
            if (!req_write) rdata_n = WORD_W'(rd_data[req_lsb +: 8]);
          end else begin
            // First half: word bytes 0.. land in lanes lane..WORD_BYTES-1.
            wr_en  = req_write;
            wr_row = req_row;
            for (int unsigned j = 0; j < WORD_BYTES; j++) begin
              wr_be[j] = (j >= 32'(req_lane));
            end
            wr_data = req_wdata >> (8 * 32'(req_lane));
            if (req_lane == '0) begin
              valid_n = 1'b1;
              if (!req_write) rdata_n = rd_data;
            end else begin
              capture = 1'b1;
              state_n = SPLIT;
            end
          end
        end
      end

      SPLIT: begin
        // Second half: remaining word bytes go to lanes 0..lane-1 of the next row.
        rd_row = sp_row;
        wr_en  = sp_write;
        wr_row = sp_row;
        for (int unsigned j = 0; j < WORD_BYTES; j++) begin
          wr_be[j] = (j < 32'(sp_lane));
        end
        wr_data = sp_wdata << (8 * (WORD_BYTES - 32'(sp_lane)));
        valid_n = 1'b1;
        if (!sp_write) rdata_n = sp_part | (rd_data >> (8 * (WORD_BYTES - 32'(sp_lane))));
        state_n = IDLE;
      end

      default: state_n = INIT;
    endcase

    ready_n = (state_n == IDLE);
  end

endmodule

// File: tb/tb_data_memory_banked.sv
// Directed, table-driven bench for data_memory_banked with default parameters.
module tb_data_memory_banked;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_size;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic        sz;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  data_memory_banked dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic drive(input logic wr, input logic sz, input logic [15:0] addr, input logic [15:0] wd);
    req_valid = 1'b1;
    req_write = wr;
    req_size  = sz;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  // Issue one request and check its response; leaves no idle gap afterwards.
  task automatic run_vec(input vec_t v, input string name);
    drive(v.wr, v.sz, v.addr, v.wdata);
    chk({name, "_ready"}, 32'(req_ready), 32'd1);
    tick();
    idle();
    if (v.lat == 2) begin
      chk({name, "_mid_valid"}, 32'(rsp_valid), 32'd0);
      chk({name, "_mid_ready"}, 32'(req_ready), 32'd0);
      tick();
    end
    chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, "_rdata"}, 32'(rsp_rdata), 32'(v.rdata));
    chk({name, "_error"}, 32'(rsp_error), 32'(v.err));
  endtask

  // Count edges until req_ready rises; INIT must take exactly 32 cycles with no responses.
  task automatic wait_init(input string name);
    int n = 0;
    int stray = 0;
    while (!req_ready && n < 40) begin
      tick();
      n++;
      if (rsp_valid) stray++;
    end
    chk({name, "_init_cycles"}, 32'(n), 32'd32);
    chk({name, "_init_no_rsp"}, 32'(stray), 32'd0);
  endtask

  function automatic vec_t mk(input logic wr, input logic sz, input logic [15:0] addr,
                              input logic [15:0] wd, input logic [15:0] rd,
                              input logic err, input int lat);
    vec_t v;
    v.wr = wr; v.sz = sz; v.addr = addr; v.wdata = wd;
    v.rdata = rd; v.err = err; v.lat = lat;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(0, 1, 16'd0,  16'h0000, 16'h0000, 0, 1);
    vecs[1]  = mk(1, 1, 16'd4,  16'h1234, 16'h0000, 0, 1);
    vecs[2]  = mk(0, 1, 16'd4,  16'h0000, 16'h1234, 0, 1);
    vecs[3]  = mk(0, 0, 16'd5,  16'h0000, 16'h0034, 0, 1);
    vecs[4]  = mk(1, 1, 16'd7,  16'hABCD, 16'h0000, 0, 2);
    vecs[5]  = mk(0, 0, 16'd7,  16'h0000, 16'h00AB, 0, 1);
    vecs[6]  = mk(0, 0, 16'd8,  16'h0000, 16'h00CD, 0, 1);
    vecs[7]  = mk(0, 1, 16'd6,  16'h0000, 16'h00AB, 0, 1);
    vecs[8]  = mk(1, 0, 16'd63, 16'h005A, 16'h0000, 0, 1);
    vecs[9]  = mk(1, 1, 16'd63, 16'hFFFF, 16'h0000, 1, 1);
    vecs[10] = mk(0, 0, 16'd63, 16'h0000, 16'h005A, 0, 1);
    vecs[11] = mk(0, 0, 16'd64, 16'h0000, 16'h0000, 1, 1);
    vecs[12] = mk(0, 1, 16'd7,  16'h0000, 16'hABCD, 0, 2);
    vecs[13] = mk(1, 0, 16'd0,  16'hEE77, 16'h0000, 0, 1);
    vecs[14] = mk(0, 1, 16'd0,  16'h0000, 16'h7700, 0, 1);
    vecs[15] = mk(0, 1, 16'd8,  16'h0000, 16'hCD00, 0, 1);

    idle();
    reset_n = 1'b0;
    tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_error", 32'(rsp_error), 32'd0);
    reset_n = 1'b1;
    wait_init("boot");

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Response is a single pulse and outputs return to zero.
    tick();
    chk("pulse_valid", 32'(rsp_valid), 32'd0);
    chk("pulse_rdata", 32'(rsp_rdata), 32'd0);
    chk("pulse_error", 32'(rsp_error), 32'd0);

    // Reset in the middle of a split write discards the second half and reclears memory.
    run_vec(mk(1, 1, 16'd10, 16'hFFFF, 16'h0000, 0, 1), "pre_fill");
    drive(1, 1, 16'd9, 16'h1234);
    tick();
    idle();
    chk("split_rst_ready", 32'(req_ready), 32'd0);
    reset_n = 1'b0;
    tick();
    chk("split_rst_valid", 32'(rsp_valid), 32'd0);
    chk("split_rst_rdy", 32'(req_ready), 32'd0);
    reset_n = 1'b1;
    wait_init("split_rst");
    run_vec(mk(0, 1, 16'd9,  16'h0000, 16'h0000, 0, 2), "post_rst_9");
    run_vec(mk(0, 1, 16'd10, 16'h0000, 16'h0000, 0, 1), "post_rst_10");
    run_vec(mk(0, 1, 16'd8,  16'h0000, 16'h0000, 0, 1), "post_rst_8");

    // Back-to-back aligned writes, one accept and one response per cycle.
    run_vec(mk(1, 1, 16'd0, 16'h1111, 16'h0000, 0, 1), "b2b_w0");
    run_vec(mk(1, 1, 16'd2, 16'h2222, 16'h0000, 0, 1), "b2b_w2");
    run_vec(mk(1, 1, 16'd4, 16'h3333, 16'h0000, 0, 1), "b2b_w4");
    tick();
    chk("b2b_end_valid", 32'(rsp_valid), 32'd0);
    run_vec(mk(0, 1, 16'd0, 16'h0000, 16'h1111, 0, 1), "b2b_r0");
    run_vec(mk(0, 1, 16'd2, 16'h0000, 16'h2222, 0, 1), "b2b_r2");
    run_vec(mk(0, 1, 16'd4, 16'h0000, 16'h3333, 0, 1), "b2b_r4");
    run_vec(mk(0, 1, 16'd1, 16'h0000, 16'h1122, 0, 2), "b2b_r1");

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
